// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module : dcache_pkg
// Brief  : Shared types, field layout and address slicing for the D-cache.
// Rev    : 1.0
// ============================================================================
package dcache_pkg;

    localparam int TAG_W      = 23;
    localparam int IDX_W      = 4;
    localparam int WORD_SEL_W = 3;
    localparam int OFFSET_W   = 5;
    localparam int WORD_W     = 32;
    localparam int ENTRY_W    = TAG_W + 2;
    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITEBACK = 3'd1,
        ST_ALLOCATE  = 3'd2,
        ST_REFILLED  = 3'd3
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:IDX_W+OFFSET_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return addr[OFFSET_W +: IDX_W];
    endfunction

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[2 +: WORD_SEL_W];
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_tag_data_array.sv
`default_nettype none
// ============================================================================
// Module : dcache_tag_data_array
// Brief  : Two-way tag/data/LRU storage, async read, single sync write port.
// Rev    : 1.0
// ============================================================================
module dcache_tag_data_array
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int LINE_W   = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [ENTRY_W-1:0] o_entry0,
    output logic [ENTRY_W-1:0] o_entry1,
    output logic [LINE_W-1:0]  o_line0,
    output logic [LINE_W-1:0]  o_line1,
    output logic               o_lru,
    input  logic               i_we,
    input  logic               i_way,
    input  logic [ENTRY_W-1:0] i_entry,
    input  logic [LINE_W-1:0]  i_line,
    input  logic               i_lru_we,
    input  logic               i_lru
);

    logic [1:0][ENTRY_W-1:0] w_entry_rd;
    logic [1:0][LINE_W-1:0]  w_line_rd;
    logic [NUM_SETS-1:0]     r_lru;

    for (genvar w = 0; w < 2; w++) begin : g_way
        logic [ENTRY_W-1:0] r_entry [NUM_SETS];
        logic [LINE_W-1:0]  r_line  [NUM_SETS];
        logic               w_sel;

        assign w_sel = i_we && (i_way == 1'(w));

        // Only tag entries are reset; line contents are meaningless until valid.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    r_entry[s] <= '0;
                end
            end else if (w_sel) begin
                r_entry[i_idx] <= i_entry;
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_sel) begin
                r_line[i_idx] <= i_line;
            end
        end

        assign w_entry_rd[w] = r_entry[i_idx];
        assign w_line_rd[w]  = r_line[i_idx];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lru <= '0;
        end else if (i_lru_we) begin
            r_lru[i_idx] <= i_lru;
        end
    end

    assign o_entry0 = w_entry_rd[0];
    assign o_entry1 = w_entry_rd[1];
    assign o_line0  = w_line_rd[0];
    assign o_line1  = w_line_rd[1];
    assign o_lru    = r_lru[i_idx];

endmodule
`default_nettype wire

// File: rtl/dcache_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dcache_wb_ctrl
// Brief  : Two-way write-back, write-allocate D-cache controller.
// Rev    : 1.0
// ============================================================================
module dcache_wb_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam logic [2:0] c_ST_IDLE      = ST_IDLE;
    localparam logic [2:0] c_ST_WRITEBACK = ST_WRITEBACK;
    localparam logic [2:0] c_ST_ALLOCATE  = ST_ALLOCATE;
    localparam logic [2:0] c_ST_REFILLED  = ST_REFILLED;

    logic [2:0]            r_state;
    logic                  r_victim;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [LINE_W-1:0]     r_mem_data;

    logic [TAG_W-1:0]      w_tag;
    logic [IDX_W-1:0]      w_idx;
    logic [WORD_SEL_W-1:0] w_word;
    logic [ENTRY_W-1:0]    w_e0, w_e1, w_vic_entry;
    logic [LINE_W-1:0]     w_l0, w_l1, w_hit_line, w_vic_line, w_merged;
    logic                  w_lru, w_req, w_hit0, w_hit1, w_hit, w_hit_way, w_victim;
    logic                  w_arr_we, w_arr_way, w_lru_we, w_lru_val;
    logic [ENTRY_W-1:0]    w_arr_entry;
    logic [LINE_W-1:0]     w_arr_line;
    logic                  w_unused_addr;

    assign w_tag         = addr_tag(cpu_addr_i[31:0]);
    assign w_idx         = addr_idx(cpu_addr_i[31:0]);
    assign w_word        = addr_word(cpu_addr_i[31:0]);
    assign w_unused_addr = ^cpu_addr_i[1:0];

    dcache_tag_data_array #(
        .NUM_SETS (NUM_SETS),
        .LINE_W   (LINE_W)
    ) u_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_idx    (w_idx),
        .o_entry0 (w_e0),
        .o_entry1 (w_e1),
        .o_line0  (w_l0),
        .o_line1  (w_l1),
        .o_lru    (w_lru),
        .i_we     (w_arr_we),
        .i_way    (w_arr_way),
        .i_entry  (w_arr_entry),
        .i_line   (w_arr_line),
        .i_lru_we (w_lru_we),
        .i_lru    (w_lru_val)
    );

    assign w_req      = cpu_MemRead_i || cpu_MemWrite_i;
    assign w_hit0     = w_e0[VALID_BIT] && (w_e0[TAG_W-1:0] == w_tag);
    assign w_hit1     = w_e1[VALID_BIT] && (w_e1[TAG_W-1:0] == w_tag);
    assign w_hit      = w_hit0 || w_hit1;
    assign w_hit_way  = !w_hit0;
    assign w_hit_line = w_hit_way ? w_l1 : w_l0;

    // Invalid ways are filled first (way 0 preferred), otherwise evict the LRU way.
    assign w_victim    = !w_e0[VALID_BIT] ? 1'b0 : (!w_e1[VALID_BIT] ? 1'b1 : w_lru);
    assign w_vic_entry = w_victim ? w_e1 : w_e0;
    assign w_vic_line  = w_victim ? w_l1 : w_l0;

    always_comb begin
        w_merged = w_hit_line;
        w_merged[{w_word, 5'b0} +: WORD_W] = cpu_data_i;
    end

    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_way   = w_hit_way;
        w_arr_entry = {1'b1, 1'b1, w_tag};
        w_arr_line  = w_merged;
        w_lru_we    = 1'b0;
        w_lru_val   = !w_hit_way;
        if ((r_state == c_ST_IDLE) && w_req && w_hit) begin
            w_lru_we = 1'b1;
            w_arr_we = cpu_MemWrite_i;
        end
        if ((r_state == c_ST_ALLOCATE) && mem_ack_i) begin
            w_arr_we    = 1'b1;
            w_arr_way   = r_victim;
            w_arr_entry = {1'b1, 1'b0, w_tag};
            w_arr_line  = mem_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= c_ST_IDLE;
            r_victim   <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_victim <= w_victim;
                        r_mem_en <= 1'b1;
                        if (w_vic_entry[VALID_BIT] && w_vic_entry[DIRTY_BIT]) begin
                            r_state    <= c_ST_WRITEBACK;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= ADDR_W'(line_addr(w_vic_entry[TAG_W-1:0], w_idx));
                            r_mem_data <= w_vic_line;
                        end else begin
                            r_state    <= c_ST_ALLOCATE;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= ADDR_W'(line_addr(w_tag, w_idx));
                        end
                    end
                end
                c_ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state    <= c_ST_ALLOCATE;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= ADDR_W'(line_addr(w_tag, w_idx));
                    end
                end
                c_ST_ALLOCATE: begin
                    if (mem_ack_i) begin
                        r_state  <= c_ST_REFILLED;
                        r_mem_en <= 1'b0;
                    end
                end
                c_ST_REFILLED: r_state <= c_ST_IDLE;
                default:       r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign cpu_stall_o  = (r_state == c_ST_IDLE) ? (w_req && !w_hit) : 1'b1;
    assign cpu_data_o   = ((r_state == c_ST_IDLE) && cpu_MemRead_i && w_hit)
                          ? w_hit_line[{w_word, 5'b0} +: WORD_W] : '0;
    assign mem_enable_o = r_mem_en;
    assign mem_write_o  = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_wb_ctrl
// Brief  : Random + directed bench against an abstract cache/memory model.
// Rev    : 1.0
// ============================================================================
module tb_dcache_wb_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_rd, cpu_wr, cpu_stall;
    logic [255:0] mem_rdata = '0;
    logic         mem_ack   = 1'b0;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_addr;
    logic         mem_en, mem_we;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dcache_wb_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .cpu_addr_i     (cpu_addr),
        .cpu_data_i     (cpu_wdata),
        .cpu_MemRead_i  (cpu_rd),
        .cpu_MemWrite_i (cpu_wr),
        .cpu_data_o     (cpu_rdata),
        .cpu_stall_o    (cpu_stall),
        .mem_data_i     (mem_rdata),
        .mem_ack_i      (mem_ack),
        .mem_data_o     (mem_wdata),
        .mem_addr_o     (mem_addr),
        .mem_enable_o   (mem_en),
        .mem_write_o    (mem_we)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] preload(input logic [26:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[k*32 +: 32] = (32'(la) * 32'd8 + 32'(k) + 32'd1) * 32'h9E3779B9;
        end
        if (la == 27'd0) begin
            l = {32'h00001111, 32'h22223333, 32'h44445555, 32'h66667777,
                 32'h88889999, 32'hAAAABBBB, 32'hCCCCDDDD, 32'hEEEEFFFF};
        end
        if (la == 27'd32) begin
            l[31:0] = 32'hE00EF00F;
        end
        return l;
    endfunction

    // Memory environment: acks after mem_lat full enable cycles, logs every transfer.
    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    int           mem_lat = 2;
    int           env_cnt = 0;
    logic [255:0] env_mem [logic [26:0]];
    txn_t         txn_q [$];

    always @(posedge clk) begin
        txn_t t;
        #1;
        if (mem_ack) begin
            mem_ack = 1'b0;
            env_cnt = 0;
        end
        if (!rst_n || !mem_en) begin
            env_cnt = 0;
        end else begin
            env_cnt++;
            if (env_cnt == mem_lat + 1) begin
                t.wr   = mem_we;
                t.addr = mem_addr;
                t.data = mem_we ? mem_wdata : '0;
                if (mem_we) env_mem[mem_addr[31:5]] = mem_wdata;
                else mem_rdata = env_mem.exists(mem_addr[31:5]) ? env_mem[mem_addr[31:5]]
                                                                : preload(mem_addr[31:5]);
                txn_q.push_back(t);
                mem_ack = 1'b1;
            end
        end
    end

    // Reference cache: plain per-set/per-way records and a separate memory image.
    logic [255:0] ref_line [16][2];
    logic [22:0]  ref_tag  [16][2];
    bit           ref_v    [16][2];
    bit           ref_d    [16][2];
    bit           ref_lru  [16];
    logic [255:0] ref_mem  [logic [26:0]];

    task automatic ref_reset();
        for (int s = 0; s < 16; s++) begin
            ref_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                ref_v[s][w] = 1'b0;
                ref_d[s][w] = 1'b0;
            end
        end
    endtask

    task automatic ref_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input int lat, output int st, output logic [31:0] rdv,
                              output bit wb, output logic [31:0] wba, output logic [255:0] wbd,
                              output bit fl, output logic [31:0] fla);
        int          idx = int'((a / 32) % 16);
        int          wsel = int'((a % 32) / 4);
        logic [22:0] tag = 23'(a / 512);
        int          way = -1;
        logic [26:0] key;
        st = 0; rdv = '0; wb = 0; wba = '0; wbd = '0; fl = 0; fla = '0;
        for (int k = 0; k < 2; k++) begin
            if (ref_v[idx][k] && ref_tag[idx][k] == tag) way = k;
        end
        if (way < 0) begin
            if (!ref_v[idx][0]) way = 0;
            else if (!ref_v[idx][1]) way = 1;
            else way = int'(ref_lru[idx]);
            st = lat + 3;
            if (ref_v[idx][way] && ref_d[idx][way]) begin
                wb  = 1;
                wba = 32'(ref_tag[idx][way]) * 512 + 32'(idx) * 32;
                wbd = ref_line[idx][way];
                ref_mem[27'(wba / 32)] = wbd;
                st = 2 * lat + 4;
            end
            fl  = 1;
            fla = (a / 32) * 32;
            key = 27'(a / 32);
            ref_line[idx][way] = ref_mem.exists(key) ? ref_mem[key] : preload(key);
            ref_v[idx][way]    = 1'b1;
            ref_d[idx][way]    = 1'b0;
            ref_tag[idx][way]  = tag;
        end
        if (wr) begin
            ref_line[idx][way][wsel*32 +: 32] = d;
            ref_d[idx][way] = 1'b1;
        end else begin
            rdv = ref_line[idx][way][wsel*32 +: 32];
        end
        ref_lru[idx] = (way == 0);
    endtask

    task automatic do_access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        int           exp_stall, cyc;
        logic [31:0]  exp_rd, wb_a, fill_a;
        logic [255:0] wb_d;
        bit           exp_wb, exp_fill;
        txn_t         t;
        mem_lat = $urandom_range(1, 4);
        ref_access(wr, a, d, mem_lat, exp_stall, exp_rd, exp_wb, wb_a, wb_d, exp_fill, fill_a);
        @(posedge clk);
        #1;
        cpu_addr = a; cpu_wdata = d; cpu_rd = rd; cpu_wr = wr;
        #2;
        cyc = 0;
        while (cpu_stall && cyc < 100) begin
            @(posedge clk);
            #3;
            cyc++;
        end
        check($sformatf("stall@%0h", a), 256'(cyc), 256'(exp_stall));
        if (rd && !wr) check($sformatf("rdata@%0h", a), 256'(cpu_rdata), 256'(exp_rd));
        check($sformatf("ntxn@%0h", a), 256'(txn_q.size()), 256'(int'(exp_wb) + int'(exp_fill)));
        if (exp_wb && txn_q.size() > 0) begin
            t = txn_q.pop_front();
            check("wb_dir", 256'(t.wr), 256'(1));
            check("wb_addr", 256'(t.addr), 256'(wb_a));
            check("wb_data", t.data, wb_d);
        end
        if (exp_fill && txn_q.size() > 0) begin
            t = txn_q.pop_front();
            check("fill_dir", 256'(t.wr), 256'(0));
            check("fill_addr", 256'(t.addr), 256'(fill_a));
        end
        txn_q.delete();
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [31:0] a;
        int          op;
        rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        ref_reset();
        repeat (3) @(posedge clk);
        #3;
        check("rst_en",    256'(mem_en),    256'(0));
        check("rst_we",    256'(mem_we),    256'(0));
        check("rst_addr",  256'(mem_addr),  256'(0));
        check("rst_data",  mem_wdata,       256'(0));
        check("rst_rdata", 256'(cpu_rdata), 256'(0));
        check("rst_stall", 256'(cpu_stall), 256'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Cold miss, hit, write hit, conflict eviction with write-back.
        do_access(0, 1, 32'h000, 32'h0);
        do_access(0, 1, 32'h004, 32'h0);
        do_access(1, 0, 32'h008, 32'h12345678);
        do_access(0, 1, 32'h008, 32'h0);
        do_access(0, 1, 32'h200, 32'h0);
        do_access(0, 1, 32'h400, 32'h0);
        check("e00ef00f_seen", 256'(ref_line[0][0][31:0]), 256'(32'hE00EF00F));

        // LRU: dirty way 0 is recently used, so clean way 1 must go.
        do_access(1, 0, 32'h020, 32'hA5A5A5A5);
        do_access(0, 1, 32'h220, 32'h0);
        do_access(0, 1, 32'h020, 32'h0);
        do_access(0, 1, 32'h420, 32'h0);

        // Read+write together behaves as a store and dirties the line.
        do_access(0, 1, 32'h040, 32'h0);
        do_access(1, 1, 32'h044, 32'hDEADBEEF);
        do_access(0, 1, 32'h044, 32'h0);
        do_access(0, 1, 32'h240, 32'h0);
        do_access(0, 1, 32'h440, 32'h0);

        // Reset while a fill is outstanding.
        mem_lat = 4;
        @(posedge clk);
        #1;
        cpu_addr = 32'h0E0; cpu_rd = 1'b1; cpu_wr = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
        end while (!(mem_en && !mem_we) && cyc < 20);
        check("fill_seen", 256'(mem_en && !mem_we), 256'(1));
        rst_n = 1'b0;
        #1;
        check("rstmid_en", 256'(mem_en), 256'(0));
        check("rstmid_we", 256'(mem_we), 256'(0));
        cpu_rd = 1'b0;
        #1;
        check("rstmid_idle", 256'(cpu_stall), 256'(0));
        check("rstmid_txn", 256'(txn_q.size()), 256'(0));
        txn_q.delete();
        ref_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_access(0, 1, 32'h0E0, 32'h0);

        // Random traffic over a small conflict-heavy address pool.
        for (int i = 0; i < 160; i++) begin
            a  = 32'($urandom_range(0, 3)) * 512 + 32'($urandom_range(0, 3)) * 32
               + 32'($urandom_range(0, 7)) * 4;
            op = $urandom_range(0, 2);
            do_access(op != 0, op != 1, a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
